scan_digit_entry: RTL and testbench
===================================

Name: scan_digit_entry

Overview:
- Parametrised successor to the single-key break-code decoder.
- Consumes the raw byte stream from the PS/2 receiver and tracks the E0 (extended) and F0 (break) prefixes in an FSM.
- On key release, decodes digit, Backspace, Escape and Enter keys, and assembles a multi-digit BCD number in a DIGITS-deep shift buffer.
- Sits between the PS/2 receiver and the numeric datapath / seven-segment display logic.

Parameters:
- DIGITS, 4: number of BCD digits held in the entry buffer; legal range 1..8.
- CW, 4: width of the count output; must satisfy 2**CW > DIGITS.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rx_byte  in  8  byte from the PS/2 receiver.
- rx_valid  in  1  one-cycle strobe; rx_byte is valid in that cycle.
- digit_valid  out  1  one-cycle pulse when a digit key release is accepted.
- digit  out  4  last decoded digit 0..9; held between pulses.
- bcd  out  4*DIGITS  live entry buffer; newest digit in bits [3:0].
- count  out  CW  number of digits currently in the buffer, 0..DIGITS.
- overflow  out  1  sticky; set when a digit arrives while count==DIGITS.
- result  out  4*DIGITS  value committed by Enter; held until the next Enter.
- entry_done  out  1  one-cycle pulse when result is updated.

Behaviour:
- Reset (asynchronous, rst=1): FSM to IDLE. All outputs 0, including bcd, result, count and overflow.
- Bytes are processed only in cycles with rx_valid=1. At most one byte arrives per cycle.
- FSM states: IDLE, EXT, BRK, EXT_BRK.
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte (make or typematic repeat) -> IDLE, no action.
  - EXT: F0 -> EXT_BRK; E0 -> EXT; any other byte -> IDLE, no action.
  - BRK: F0 -> BRK; E0 -> EXT; any other byte -> decode as a normal-key release, then -> IDLE.
  - EXT_BRK: F0 -> EXT_BRK; any other byte -> decode as an extended-key release, then -> IDLE.
- Normal release codes:
  - Top-row digits: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9.
  - 66 = Backspace, 76 = Escape, 5A = Enter.
- Extended release codes: 5A = Enter (keypad Enter, only with the macro below). All other extended codes are ignored.
- Unknown release codes are ignored; the FSM still returns to IDLE.
- All actions are registered and take effect the cycle after the rx_valid cycle (latency 1).
- Digit release:
  - digit <= value; digit_valid pulses.
  - If count<DIGITS: bcd <= {bcd[4*DIGITS-5:0], value}; count++.
  - If count==DIGITS: bcd and count unchanged; overflow <= 1.
- Backspace:
  - If count>0: bcd <= {4'h0, bcd[4*DIGITS-1:4]}; count--.
  - If count==0: no change.
  - overflow <= 0 in both cases.
- Escape: bcd <= 0, count <= 0, overflow <= 0.
- Enter: result <= bcd; entry_done pulses; then bcd <= 0, count <= 0, overflow <= 0.
  - Enter with count==0 still commits result=0 and pulses entry_done.
- digit_valid and entry_done are never high in the same cycle.
- Assertion of rst mid-sequence (e.g. after F0) discards the prefix; the next byte is decoded from IDLE.

Optional Feature:
- Macro: SCAN_DIGIT_ENTRY_KEYPAD_EN.
- Defined:
  - Numeric keypad releases are also decoded as digits: 70=0, 69=1, 72=2, 7A=3, 6B=4, 73=5, 74=6, 6C=7, 75=8, 7D=9.
  - E0 F0 5A (keypad Enter) acts as Enter.
- Not defined: keypad codes and E0 F0 5A are treated as unknown and ignored. The FSM sequencing is unchanged.

Test Plan:
- Reset, then F0 16, F0 1E, F0 26 (DIGITS=4) -> three digit_valid pulses with digit=1,2,3; bcd=16'h0123; count=3; overflow=0.
- Fill 4 digits (1,2,3,4), then F0 45 -> digit_valid pulses with digit=0; bcd stays 16'h1234; count=4; overflow=1. Then F0 66 -> bcd=16'h0123; count=3; overflow=0.
- Enter digits 9,8, then F0 5A -> entry_done one cycle after the 5A strobe; result=16'h0098; bcd=0; count=0. Make-only bytes 16, 16 (typematic) -> no pulses, no change.
- E0 F0 5A:
  - With macro: entry_done pulses.
  - Without macro: no pulse, FSM back in IDLE; a following F0 16 yields digit=1.
- Assert rst after F0 only, release, then send 16 -> no digit_valid (treated as a make code). Then F0 76 after digits 5,6 -> bcd=0, count=0.
- With macro: F0 70, F0 7D -> digits 0,9; bcd=16'h0009; count=2.

Source files
------------

// File: rtl/scan_digit_entry.sv
// PS/2 break-code digit entry: E0/F0 prefix FSM feeding a DIGITS-deep BCD buffer.
// Define SCAN_DIGIT_ENTRY_KEYPAD_EN to also accept keypad digits and keypad Enter.
module scan_digit_entry #(
    parameter int DIGITS = 4,
    parameter int CW     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    output logic                  digit_valid,
    output logic [3:0]            digit,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   result,
    output logic                  entry_done
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] EXT     = 2'd1;
    localparam logic [1:0] BRK     = 2'd2;
    localparam logic [1:0] EXT_BRK = 2'd3;

    localparam logic [CW-1:0] FULL = CW'(DIGITS);

    logic [1:0] state, state_nxt;
    logic       rel_norm, rel_ext;
    logic       is_digit, is_bs, is_esc, is_ent;
    logic [3:0] dval;

    always_comb begin
        state_nxt = state;
        rel_norm  = 1'b0;
        rel_ext   = 1'b0;
        if (rx_valid) begin
            case (state)
                IDLE: state_nxt = (rx_byte == 8'hE0) ? EXT :
                                  (rx_byte == 8'hF0) ? BRK : IDLE;
                EXT:  state_nxt = (rx_byte == 8'hE0) ? EXT :
                                  (rx_byte == 8'hF0) ? EXT_BRK : IDLE;
                BRK: begin
                    if (rx_byte == 8'hF0)      state_nxt = BRK;
                    else if (rx_byte == 8'hE0) state_nxt = EXT;
                    else begin
                        state_nxt = IDLE;
                        rel_norm  = 1'b1;
                    end
                end
                default: begin
                    // an E0 here is simply an unknown extended release
                    if (rx_byte == 8'hF0) state_nxt = EXT_BRK;
                    else begin
                        state_nxt = IDLE;
                        rel_ext   = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        is_digit = 1'b0;
        dval     = 4'd0;
        is_bs    = 1'b0;
        is_esc   = 1'b0;
        is_ent   = 1'b0;
        if (rel_norm) begin
            is_digit = 1'b1;
            case (rx_byte)
                8'h45: dval = 4'd0;
                8'h16: dval = 4'd1;
                8'h1E: dval = 4'd2;
                8'h26: dval = 4'd3;
                8'h25: dval = 4'd4;
                8'h2E: dval = 4'd5;
                8'h36: dval = 4'd6;
                8'h3D: dval = 4'd7;
                8'h3E: dval = 4'd8;
                8'h46: dval = 4'd9;
`ifdef SCAN_DIGIT_ENTRY_KEYPAD_EN
                8'h70: dval = 4'd0;
                8'h69: dval = 4'd1;
                8'h72: dval = 4'd2;
                8'h7A: dval = 4'd3;
                8'h6B: dval = 4'd4;
                8'h73: dval = 4'd5;
                8'h74: dval = 4'd6;
                8'h6C: dval = 4'd7;
                8'h75: dval = 4'd8;
                8'h7D: dval = 4'd9;
`endif
                default: is_digit = 1'b0;
            endcase
            is_bs  = (rx_byte == 8'h66);
            is_esc = (rx_byte == 8'h76);
            is_ent = (rx_byte == 8'h5A);
        end
`ifdef SCAN_DIGIT_ENTRY_KEYPAD_EN
        if (rel_ext && rx_byte == 8'h5A) is_ent = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            digit_valid <= 1'b0;
            digit       <= 4'd0;
            bcd         <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            result      <= '0;
            entry_done  <= 1'b0;
        end else begin
            state       <= state_nxt;
            digit_valid <= 1'b0;
            entry_done  <= 1'b0;
            if (is_digit) begin
                digit       <= dval;
                digit_valid <= 1'b1;
                if (count < FULL) begin
                    // shift form keeps DIGITS==1 legal
                    bcd   <= (bcd << 4) | {{(4*DIGITS-4){1'b0}}, dval};
                    count <= count + 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (is_bs) begin
                if (count != '0) begin
                    bcd   <= bcd >> 4;
                    count <= count - 1'b1;
                end
                overflow <= 1'b0;
            end else if (is_esc) begin
                bcd      <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else if (is_ent) begin
                result     <= bcd;
                entry_done <= 1'b1;
                bcd        <= '0;
                count      <= '0;
                overflow   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_scan_digit_entry.sv
// Directed bench for scan_digit_entry (DIGITS=4); follows SCAN_DIGIT_ENTRY_KEYPAD_EN if defined.
module tb_scan_digit_entry;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic        digit_valid, entry_done, overflow;
    logic [3:0]  digit, count;
    logic [15:0] bcd, result;
    logic        s_dv, s_ed;
    int          total = 0;
    int          bad = 0;

    scan_digit_entry #(.DIGITS(4), .CW(4)) dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .digit_valid(digit_valid), .digit(digit), .bcd(bcd), .count(count),
        .overflow(overflow), .result(result), .entry_done(entry_done)
    );

    always #5 clk = ~clk;

    // strobe one byte, then capture the pulses one cycle later
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        s_dv = digit_valid;
        s_ed = entry_done;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++; if ({digit_valid, digit, bcd, count, overflow, result, entry_done} !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", {digit_valid, digit, bcd, count, overflow, result, entry_done}); end
        rst = 1'b0;
    endtask

    task automatic test_digits;
        logic [7:0] codes [3] = '{8'h16, 8'h1E, 8'h26};
        for (int i = 0; i < 3; i++) begin
            send(8'hF0); send(codes[i]);
            total++; if (s_dv !== 1'b1 || digit !== 4'(i + 1)) begin bad++; $display("FAIL digit_%0d got dv=%b d=%0d want dv=1 d=%0d", i, s_dv, digit, i + 1); end
        end
        total++; if (bcd !== 16'h0123 || count !== 4'd3 || overflow !== 1'b0) begin bad++; $display("FAIL digits_buf got bcd=%h cnt=%0d ov=%b want 0123/3/0", bcd, count, overflow); end
    endtask

    task automatic test_overflow;
        send(8'hF0); send(8'h25);
        total++; if (bcd !== 16'h1234 || count !== 4'd4) begin bad++; $display("FAIL fill got bcd=%h cnt=%0d want 1234/4", bcd, count); end
        send(8'hF0); send(8'h45);
        total++; if (s_dv !== 1'b1 || digit !== 4'd0) begin bad++; $display("FAIL ovf_pulse got dv=%b d=%0d want 1/0", s_dv, digit); end
        total++; if (bcd !== 16'h1234 || count !== 4'd4 || overflow !== 1'b1) begin bad++; $display("FAIL ovf_buf got bcd=%h cnt=%0d ov=%b want 1234/4/1", bcd, count, overflow); end
        send(8'hF0); send(8'h66);
        total++; if (bcd !== 16'h0123 || count !== 4'd3 || overflow !== 1'b0) begin bad++; $display("FAIL backspace got bcd=%h cnt=%0d ov=%b want 0123/3/0", bcd, count, overflow); end
    endtask

    task automatic test_enter;
        send(8'hF0); send(8'h76);
        total++; if (bcd !== 16'h0000 || count !== 4'd0) begin bad++; $display("FAIL esc_clear got bcd=%h cnt=%0d want 0/0", bcd, count); end
        send(8'hF0); send(8'h46);
        send(8'hF0); send(8'h3E);
        send(8'hF0); send(8'h5A);
        total++; if (s_ed !== 1'b1 || s_dv !== 1'b0) begin bad++; $display("FAIL enter_pulse got ed=%b dv=%b want 1/0", s_ed, s_dv); end
        total++; if (result !== 16'h0098 || bcd !== 16'h0000 || count !== 4'd0) begin bad++; $display("FAIL enter_commit got res=%h bcd=%h cnt=%0d want 0098/0/0", result, bcd, count); end
        @(negedge clk);
        total++; if (entry_done !== 1'b0) begin bad++; $display("FAIL enter_one_cycle got ed=%b want 0", entry_done); end
        send(8'h16); send(8'h16);
        total++; if (s_dv !== 1'b0 || count !== 4'd0 || bcd !== 16'h0000) begin bad++; $display("FAIL make_only got dv=%b cnt=%0d bcd=%h want 0/0/0", s_dv, count, bcd); end
        send(8'hF0); send(8'h5A);
        total++; if (s_ed !== 1'b1 || result !== 16'h0000) begin bad++; $display("FAIL enter_empty got ed=%b res=%h want 1/0000", s_ed, result); end
    endtask

    task automatic test_ext_enter;
        send(8'hF0); send(8'h3D);
        send(8'hE0); send(8'hF0); send(8'h5A);
`ifdef SCAN_DIGIT_ENTRY_KEYPAD_EN
        total++; if (s_ed !== 1'b1 || result !== 16'h0007 || count !== 4'd0) begin bad++; $display("FAIL ext_enter got ed=%b res=%h cnt=%0d want 1/0007/0", s_ed, result, count); end
        send(8'hF0); send(8'h16);
        total++; if (s_dv !== 1'b1 || digit !== 4'd1 || bcd !== 16'h0001) begin bad++; $display("FAIL after_ext got dv=%b d=%0d bcd=%h want 1/1/0001", s_dv, digit, bcd); end
`else
        total++; if (s_ed !== 1'b0 || result !== 16'h0000 || bcd !== 16'h0007) begin bad++; $display("FAIL ext_enter_off got ed=%b res=%h bcd=%h want 0/0000/0007", s_ed, result, bcd); end
        send(8'hF0); send(8'h16);
        total++; if (s_dv !== 1'b1 || digit !== 4'd1 || bcd !== 16'h0071) begin bad++; $display("FAIL after_ext got dv=%b d=%0d bcd=%h want 1/1/0071", s_dv, digit, bcd); end
`endif
        // extended digit codes are not digits
        send(8'hE0); send(8'hF0); send(8'h16);
        total++; if (s_dv !== 1'b0) begin bad++; $display("FAIL ext_digit_ignored got dv=%b want 0", s_dv); end
    endtask

    task automatic test_rst_mid;
        send(8'hF0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        total++; if (bcd !== 16'h0000 || count !== 4'd0 || result !== 16'h0000) begin bad++; $display("FAIL mid_reset got bcd=%h cnt=%0d res=%h want 0/0/0", bcd, count, result); end
        send(8'h16);
        total++; if (s_dv !== 1'b0 || count !== 4'd0) begin bad++; $display("FAIL prefix_dropped got dv=%b cnt=%0d want 0/0", s_dv, count); end
        send(8'hF0); send(8'h2E);
        send(8'hF0); send(8'h36);
        total++; if (bcd !== 16'h0056 || count !== 4'd2) begin bad++; $display("FAIL pre_esc got bcd=%h cnt=%0d want 0056/2", bcd, count); end
        send(8'hF0); send(8'h76);
        total++; if (bcd !== 16'h0000 || count !== 4'd0 || overflow !== 1'b0) begin bad++; $display("FAIL escape got bcd=%h cnt=%0d ov=%b want 0/0/0", bcd, count, overflow); end
    endtask

    task automatic test_keypad;
        send(8'hF0); send(8'h70);
`ifdef SCAN_DIGIT_ENTRY_KEYPAD_EN
        total++; if (s_dv !== 1'b1 || digit !== 4'd0) begin bad++; $display("FAIL kp0 got dv=%b d=%0d want 1/0", s_dv, digit); end
        send(8'hF0); send(8'h7D);
        total++; if (s_dv !== 1'b1 || digit !== 4'd9 || bcd !== 16'h0009 || count !== 4'd2) begin bad++; $display("FAIL kp9 got dv=%b d=%0d bcd=%h cnt=%0d want 1/9/0009/2", s_dv, digit, bcd, count); end
`else
        total++; if (s_dv !== 1'b0) begin bad++; $display("FAIL kp0_off got dv=%b want 0", s_dv); end
        send(8'hF0); send(8'h7D);
        total++; if (s_dv !== 1'b0 || count !== 4'd0 || bcd !== 16'h0000) begin bad++; $display("FAIL kp9_off got dv=%b cnt=%0d bcd=%h want 0/0/0", s_dv, count, bcd); end
`endif
    endtask

    task automatic test_back_to_back;
        // repeated F0 stays in break; BRK then E0 goes extended
        send(8'hF0); send(8'hF0); send(8'h26);
        total++; if (s_dv !== 1'b1 || digit !== 4'd3) begin bad++; $display("FAIL double_f0 got dv=%b d=%0d want 1/3", s_dv, digit); end
        send(8'hF0); send(8'hE0); send(8'h26);
        total++; if (s_dv !== 1'b0) begin bad++; $display("FAIL brk_to_ext got dv=%b want 0", s_dv); end
        send(8'hF0); send(8'h66);
        send(8'hF0); send(8'h66);
        send(8'hF0); send(8'h66);
        send(8'hF0); send(8'h66);
        total++; if (bcd !== 16'h0000 || count !== 4'd0) begin bad++; $display("FAIL bs_empty got bcd=%h cnt=%0d want 0/0", bcd, count); end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_overflow();
        test_enter();
        test_ext_enter();
        test_rst_mid();
        test_keypad();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
